// File: rtl/cpu64_l2_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// cpu64_l2_alloc_ctrl
//
// Sequences L2 way allocation for the miss handlers. One allocation is in
// flight at a time:
//   IDLE   : round-robin pick among requesters, grant pulse, tag read strobe
//   LOOKUP : tag state arrives, feed valid mask to PLRU, latch victim
//   EVICT  : dirty victim -> hold writeback request until acknowledged
//   RESP   : present allocated way; on consumer handshake pulse the PLRU
//            update and advance the round-robin pointer past the winner
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_set_i   per-requester request and set (slice r*SET_W)
//   req_gnt_o               one-hot single-cycle grant
//   tag_rd_o/tag_set_o      tag array read strobe and set
//   tag_valid_i/tag_dirty_i per-way state, returned the cycle after tag_rd_o
//   plru_set_o/plru_valid_o PLRU set index and valid mask (mask only in LOOKUP)
//   plru_victim_i           combinational victim from the PLRU
//   plru_access_o/plru_way_o PLRU MRU update strobe and way
//   wb_req_o/wb_set_o/wb_way_o/wb_ack_i  writeback handshake for dirty victim
//   alloc_valid_o/alloc_id_o/alloc_way_o/alloc_evicted_o/alloc_ready_i
//                           allocation result handshake back to the MSHR
// -----------------------------------------------------------------------------
module cpu64_l2_alloc_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int SET_W   = 8,
  parameter int WAYS    = 16,
  parameter int WAY_W   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*SET_W-1:0] req_set_i,
  output logic [NUM_REQ-1:0]       req_gnt_o,
  output logic                     tag_rd_o,
  output logic [SET_W-1:0]         tag_set_o,
  input  logic [WAYS-1:0]          tag_valid_i,
  input  logic [WAYS-1:0]          tag_dirty_i,
  output logic [SET_W-1:0]         plru_set_o,
  output logic [WAYS-1:0]          plru_valid_o,
  input  logic [WAY_W-1:0]         plru_victim_i,
  output logic                     plru_access_o,
  output logic [WAY_W-1:0]         plru_way_o,
  output logic                     wb_req_o,
  output logic [SET_W-1:0]         wb_set_o,
  output logic [WAY_W-1:0]         wb_way_o,
  input  logic                     wb_ack_i,
  output logic                     alloc_valid_o,
  output logic [ID_W-1:0]          alloc_id_o,
  output logic [WAY_W-1:0]         alloc_way_o,
  output logic                     alloc_evicted_o,
  input  logic                     alloc_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EVICT  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] victim_q;
  logic             evicted_q;

  logic [ID_W:0]    pick_res;
  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic [SET_W-1:0] pick_set;
  logic             victim_valid;
  logic             victim_dirty;
  logic             wb_hs;
  logic             resp_hs;

  // Returns {found, index}: first asserted request at or after ptr, wrapping.
  // Scanning the offsets downwards lets the smallest offset win.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Pointer advance that wraps at NUM_REQ rather than at 2**ID_W.
  function automatic logic [ID_W-1:0] rr_advance(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  assign pick_res = rr_pick(req_valid_i, rr_ptr);
  // No grant may be issued in a cycle that reset is wiping out.
  assign pick_vld = pick_res[ID_W] & ~rst_i;
  assign pick_id  = pick_res[ID_W-1:0];

  always_comb begin
    pick_set = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (ID_W'(r) == pick_id) begin
        pick_set = req_set_i[r*SET_W +: SET_W];
      end
    end
  end

  // A line only needs writing back if it is both valid and dirty.
  assign victim_valid = tag_valid_i[plru_victim_i];
  assign victim_dirty = victim_valid & tag_dirty_i[plru_victim_i];

  assign wb_hs   = (state == ST_EVICT) & wb_ack_i;
  assign resp_hs = (state == ST_RESP) & alloc_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_nxt = victim_dirty ? ST_EVICT : ST_RESP;
      end
      ST_EVICT: begin
        if (wb_hs) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_hs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latched transaction context and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      set_q     <= '0;
      victim_q  <= '0;
      evicted_q <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && pick_vld) begin
        id_q  <= pick_id;
        set_q <= pick_set;
      end
      if (state == ST_LOOKUP) begin
        victim_q  <= plru_victim_i;
        evicted_q <= victim_valid;
      end
      if (resp_hs) begin
        rr_ptr <= rr_advance(id_q);
      end
    end
  end

  // Output logic
  always_comb begin
    req_gnt_o       = '0;
    tag_rd_o        = 1'b0;
    tag_set_o       = set_q;
    plru_set_o      = set_q;
    plru_valid_o    = '0;
    plru_access_o   = 1'b0;
    plru_way_o      = victim_q;
    wb_req_o        = 1'b0;
    wb_set_o        = set_q;
    wb_way_o        = victim_q;
    alloc_valid_o   = 1'b0;
    alloc_id_o      = id_q;
    alloc_way_o     = victim_q;
    alloc_evicted_o = evicted_q;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          tag_rd_o = 1'b1;
          // The tag array samples the set alongside the strobe, before the
          // set register has captured it.
          tag_set_o = pick_set;
          for (int r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == pick_id) begin
              req_gnt_o[r] = 1'b1;
            end
          end
        end
      end
      ST_LOOKUP: begin
        plru_valid_o = tag_valid_i;
      end
      ST_EVICT: begin
        wb_req_o = 1'b1;
      end
      ST_RESP: begin
        alloc_valid_o = 1'b1;
        // Exactly one MRU update per allocation, on the handshake cycle.
        plru_access_o = alloc_ready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu64_l2_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu64_l2_alloc_ctrl
//
// Directed scenarios followed by randomized allocations. A small reference
// model tracks the round-robin pointer and derives grant, eviction and
// writeback expectations from the allocation rules; every cycle of each
// allocation is compared against it.
// -----------------------------------------------------------------------------
module tb_cpu64_l2_alloc_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int SET_W   = 8;
  localparam int WAYS    = 16;
  localparam int WAY_W   = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic [NUM_REQ-1:0]       req_valid_i = '0;
  logic [NUM_REQ*SET_W-1:0] req_set_i;
  logic [NUM_REQ-1:0]       req_gnt_o;
  logic                     tag_rd_o;
  logic [SET_W-1:0]         tag_set_o;
  logic [WAYS-1:0]          tag_valid_i = '0;
  logic [WAYS-1:0]          tag_dirty_i = '0;
  logic [SET_W-1:0]         plru_set_o;
  logic [WAYS-1:0]          plru_valid_o;
  logic [WAY_W-1:0]         plru_victim_i = '0;
  logic                     plru_access_o;
  logic [WAY_W-1:0]         plru_way_o;
  logic                     wb_req_o;
  logic [SET_W-1:0]         wb_set_o;
  logic [WAY_W-1:0]         wb_way_o;
  logic                     wb_ack_i = 1'b0;
  logic                     alloc_valid_o;
  logic [ID_W-1:0]          alloc_id_o;
  logic [WAY_W-1:0]         alloc_way_o;
  logic                     alloc_evicted_o;
  logic                     alloc_ready_i = 1'b0;

  logic [SET_W-1:0]   set_tab [NUM_REQ];
  logic [NUM_REQ-1:0] req_mask = '0;
  int                 model_rr = 0;
  int                 n_pass = 0;
  int                 n_total = 0;
  int                 n_fail = 0;

  assign req_set_i = {set_tab[3], set_tab[2], set_tab[1], set_tab[0]};

  always #5 clk_i = ~clk_i;

  cpu64_l2_alloc_ctrl #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .SET_W(SET_W), .WAYS(WAYS), .WAY_W(WAY_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_set_i(req_set_i), .req_gnt_o(req_gnt_o),
    .tag_rd_o(tag_rd_o), .tag_set_o(tag_set_o),
    .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i),
    .plru_set_o(plru_set_o), .plru_valid_o(plru_valid_o),
    .plru_victim_i(plru_victim_i), .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
    .wb_req_o(wb_req_o), .wb_set_o(wb_set_o), .wb_way_o(wb_way_o), .wb_ack_i(wb_ack_i),
    .alloc_valid_o(alloc_valid_o), .alloc_id_o(alloc_id_o), .alloc_way_o(alloc_way_o),
    .alloc_evicted_o(alloc_evicted_o), .alloc_ready_i(alloc_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after the pointer, wrapping around the ring.
  function automatic int model_pick(input logic [NUM_REQ-1:0] m, input int rr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (m[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    req_mask      = '0;
    req_valid_i   = '0;
    wb_ack_i      = 1'b0;
    alloc_ready_i = 1'b0;
    rst_i         = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_rr = 0;
    @(negedge clk_i);
    chk("rst_gnt", req_gnt_o, 0);
    chk("rst_tag_rd", tag_rd_o, 0);
    chk("rst_tag_set", tag_set_o, 0);
    chk("rst_plru_set", plru_set_o, 0);
    chk("rst_plru_valid", plru_valid_o, 0);
    chk("rst_plru_access", plru_access_o, 0);
    chk("rst_plru_way", plru_way_o, 0);
    chk("rst_wb_req", wb_req_o, 0);
    chk("rst_wb_set", wb_set_o, 0);
    chk("rst_wb_way", wb_way_o, 0);
    chk("rst_alloc_valid", alloc_valid_o, 0);
    chk("rst_alloc_id", alloc_id_o, 0);
    chk("rst_alloc_way", alloc_way_o, 0);
    chk("rst_alloc_evicted", alloc_evicted_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  // One allocation starting with the DUT idle and req_mask non-empty.
  // ack_dly: cycles wb_req stays high (ack in the last); rdy_dly: cycles
  // alloc_ready stays low before the handshake.
  task automatic alloc_txn(input logic [WAYS-1:0] tv, input logic [WAYS-1:0] td,
                           input logic [WAY_W-1:0] vic, input int ack_dly,
                           input int rdy_dly, input bit keep, output int gid);
    int   id;
    logic evicted;
    logic dirty;
    id  = model_pick(req_mask, model_rr);
    gid = id;
    evicted = tv[vic];
    dirty   = tv[vic] & td[vic];
    tag_valid_i   = tv;
    tag_dirty_i   = td;
    plru_victim_i = vic;
    req_valid_i   = req_mask;
    alloc_ready_i = 1'b0;
    wb_ack_i      = 1'b0;
    @(negedge clk_i);
    chk("grant", req_gnt_o, 4'b0001 << id);
    chk("tag_rd", tag_rd_o, 1);
    chk("tag_set", tag_set_o, set_tab[id]);
    chk("idle_alloc_valid", alloc_valid_o, 0);
    chk("idle_plru_valid", plru_valid_o, 0);
    @(posedge clk_i);
    #1;
    if (!keep) req_mask[id] = 1'b0;
    req_valid_i = req_mask;
    @(negedge clk_i);
    chk("lookup_gnt", req_gnt_o, 0);
    chk("lookup_tag_rd", tag_rd_o, 0);
    chk("lookup_plru_valid", plru_valid_o, tv);
    chk("lookup_plru_set", plru_set_o, set_tab[id]);
    chk("lookup_wb_req", wb_req_o, 0);
    chk("lookup_alloc_valid", alloc_valid_o, 0);
    chk("lookup_plru_access", plru_access_o, 0);
    @(posedge clk_i);
    #1;
    if (dirty) begin
      for (int k = 0; k < ack_dly; k++) begin
        wb_ack_i = (k == ack_dly - 1);
        @(negedge clk_i);
        chk("evict_wb_req", wb_req_o, 1);
        chk("evict_wb_set", wb_set_o, set_tab[id]);
        chk("evict_wb_way", wb_way_o, vic);
        chk("evict_alloc_valid", alloc_valid_o, 0);
        chk("evict_gnt", req_gnt_o, 0);
        chk("evict_plru_valid", plru_valid_o, 0);
        @(posedge clk_i);
        #1;
      end
      wb_ack_i = 1'b0;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      alloc_ready_i = (k == rdy_dly);
      @(negedge clk_i);
      chk("resp_alloc_valid", alloc_valid_o, 1);
      chk("resp_alloc_id", alloc_id_o, id);
      chk("resp_alloc_way", alloc_way_o, vic);
      chk("resp_alloc_evicted", alloc_evicted_o, evicted);
      chk("resp_wb_req", wb_req_o, 0);
      chk("resp_gnt", req_gnt_o, 0);
      chk("resp_plru_access", plru_access_o, (k == rdy_dly));
      if (k == rdy_dly) chk("resp_plru_way", plru_way_o, vic);
      @(posedge clk_i);
      #1;
    end
    alloc_ready_i = 1'b0;
    model_rr = (id + 1) % NUM_REQ;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gid;
    int t4_exp [5];
    logic [NUM_REQ-1:0] nm;
    t4_exp = '{0, 2, 3, 0, 2};
    for (int r = 0; r < NUM_REQ; r++) set_tab[r] = '0;
    @(posedge clk_i);
    #1;
    do_reset();

    // T1: clean invalid victim, way 5
    set_tab[1] = 8'h12;
    req_mask = 4'b0010;
    alloc_txn(16'hFFDF, 16'h0000, 4'd5, 1, 0, 1'b0, gid);
    chk("t1_id", gid, 1);

    // T2: dirty valid victim 9, writeback held 4 cycles
    req_mask = 4'b0010;
    alloc_txn(16'hFFFF, 16'h0200, 4'd9, 4, 0, 1'b0, gid);

    // T3: valid but clean victim 3 (other ways dirty)
    req_mask = 4'b0010;
    alloc_txn(16'hFFFF, 16'hFFF7, 4'd3, 1, 0, 1'b0, gid);

    // T4: requesters 0,2,3 held continuously from a fresh pointer
    do_reset();
    set_tab[0] = 8'hA0;
    set_tab[2] = 8'hC2;
    set_tab[3] = 8'hD3;
    req_mask = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      alloc_txn(16'hF0F0, 16'h0F0F, 4'(i + 4), 1, 0, 1'b1, gid);
      chk("t4_order", gid, t4_exp[i]);
    end

    // T5: consumer stalls 3 cycles in RESP
    req_mask = 4'b0001;
    alloc_txn(16'hFFFF, 16'h0000, 4'd12, 1, 3, 1'b0, gid);

    // T6: reset while waiting for writeback acknowledge
    req_mask = 4'b1000;
    set_tab[3] = 8'h5A;
    tag_valid_i   = 16'hFFFF;
    tag_dirty_i   = 16'hFFFF;
    plru_victim_i = 4'd7;
    req_valid_i   = req_mask;
    @(negedge clk_i);
    chk("t6_gnt", req_gnt_o, 4'b1000);
    @(posedge clk_i);
    #1;
    req_mask    = '0;
    req_valid_i = '0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("t6_wb_req", wb_req_o, 1);
    chk("t6_wb_set", wb_set_o, 8'h5A);
    chk("t6_wb_way", wb_way_o, 7);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    wb_ack_i = 1'b1;
    model_rr = 0;
    @(negedge clk_i);
    chk("t6_post_wb_req", wb_req_o, 0);
    chk("t6_post_wb_set", wb_set_o, 0);
    chk("t6_post_wb_way", wb_way_o, 0);
    chk("t6_post_alloc_valid", alloc_valid_o, 0);
    chk("t6_post_plru_access", plru_access_o, 0);
    chk("t6_post_gnt", req_gnt_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("t6_stray_wb_req", wb_req_o, 0);
      chk("t6_stray_alloc_valid", alloc_valid_o, 0);
      chk("t6_stray_plru_access", plru_access_o, 0);
    end
    @(posedge clk_i);
    #1 wb_ack_i = 1'b0;
    set_tab[2] = 8'h33;
    req_mask = 4'b0100;
    alloc_txn(16'h00FF, 16'h0000, 4'd9, 1, 0, 1'b0, gid);
    chk("t6_recover_id", gid, 2);

    // Randomized allocations against the reference model
    for (int t = 0; t < 24; t++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req_mask[r]) set_tab[r] = 8'($urandom);
      end
      nm = 4'($urandom);
      if (nm == 4'b0000) nm = 4'($urandom_range(1, 15));
      req_mask = req_mask | nm;
      alloc_txn(16'($urandom), 16'($urandom), 4'($urandom),
                $urandom_range(1, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), gid);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
